uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single memory-mapped UART transmitter between NUM_REQ byte producers, e.g. the CPU debug path, a boot-status reporter and a test-pattern source.
- Arbitrates round-robin among the requesters.
- Drives the UART register bus to send each granted byte: load DOUT, then set Status GO, then poll Status until the UART clears it.
- Acknowledges the requester when the UART has finished; flags an error if the UART never finishes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 65535, maximum POLL cycles before abort (fits 16-bit counter).

Ports:
- clk  in  1  system clock; same clock as the UART register interface.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester send request, level.
- req_data  in  NUM_REQ*8  byte per requester; requester i occupies bits [8i+7:8i].
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse coincident with ack when the transfer timed out.
- busy  out  1  high in every state except IDLE.
- grant_id  out  3  index of the current or last granted requester.
- uart_we  out  1  UART writeEnable.
- uart_re  out  1  UART readEnable.
- uart_sel  out  2  UART regSelect.
- uart_wdata  out  8  UART writeData.
- uart_rdata  in  8  UART Data (read data, valid while uart_re=1).

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, grant_id=0, byte_q=0, tmo_cnt=0, timed_out=0. All outputs are 0.
- UART bus outputs are decoded combinationally from state. ack and err are also Moore outputs, driven in DONE.
- IDLE: all bus outputs 0. If any req bit is 1:
  - select the first set bit at or after rr_ptr, searching with wrap-around;
  - latch grant_id and byte_q = req_data[grant];
  - go to LOAD.
  - Requests are sampled only in IDLE.
- LOAD (1 cycle): uart_we=1, uart_sel=REG_DOUT, uart_wdata=byte_q. Next state GO.
- GO (1 cycle): uart_we=1, uart_sel=REG_STATUS, uart_wdata=STATUS_GO (8'h01). Clear tmo_cnt. Next state POLL.
- POLL: uart_re=1, uart_sel=REG_STATUS, uart_rdata sampled each cycle.
  - If uart_rdata[0]=0, go to DONE with timed_out=0.
  - Else if tmo_cnt == TIMEOUT_CYCLES-1, go to ABORT.
  - Else tmo_cnt increments.
- ABORT (1 cycle): uart_we=1, uart_sel=REG_STATUS, uart_wdata=8'h00. Set timed_out=1. Next state DONE.
- DONE (1 cycle):
  - ack[grant_id]=1; err=timed_out.
  - rr_ptr = (grant_id+1) mod NUM_REQ.
  - Clear timed_out. Next state IDLE.
- Minimum latency: a request seen in IDLE at cycle 0 gives LOAD@1, GO@2, POLL@3. Ack no earlier than cycle 5, i.e. one cycle after the first POLL sample showing bit0=0.
- Requester contract:
  - hold req and req_data stable until ack;
  - drop req in the ack cycle or the cycle after.
  - A req still high when the FSM re-enters IDLE is treated as a new request, and the requester is re-granted only after the other pending requesters (fairness).
- Simultaneous requests: exactly one grant. With rr_ptr=0 and req=4'b1010, grant 1, then 3.
- A req that deasserts mid-transfer does not abort the transfer; ack is still pulsed.
- Reset asserted mid-transfer: immediate return to IDLE with the bus idle. The UART is reset by the same system reset.
- Exactly one of uart_we or uart_re is active in any cycle, or neither (IDLE, DONE).
- The arbiter never drives uart_sel=REG_DIN.

Decomposition:
- Package uart_ctrl_pkg holds:
  - the state enum {IDLE, LOAD, GO, POLL, ABORT, DONE};
  - REG_DOUT=2'b00, REG_DIN=2'b01, REG_STATUS=2'b10;
  - STATUS_GO=8'h01, STATUS_BUSY_BIT=1, STATUS_GO_BIT=0.
- One sub-module, rr_arbiter (parameter N): inputs req and ptr, outputs a one-hot grant and a binary grant index. Purely combinational, instantiated once.

Test Plan:
- Single byte: req=4'b0001 with req_data[7:0]=8'h41, UART model clears Status after 20 cycles. Required: bus writes DOUT=8'h41, then Status=8'h01, then Status reads; ack[0] pulses once; err=0; uart tx frame carries 8'h41.
- Contention: req=4'b1111 held, bytes 8'hA0..8'hA3. Required: grant order 0,1,2,3,0; four acks; no overlapping bus transactions.
- Round-robin pointer: after servicing requester 2, apply req=4'b0101. Required: grant 0 is skipped in favour of... no — search starts at 3, wraps, so grant 0 first, then 2.
- Timeout: TIMEOUT_CYCLES=8 and the UART model never clears Status[0]. Required: 8 POLL cycles, ABORT writes Status=8'h00, then ack and err pulse together; busy drops the next cycle.
- Async reset mid-POLL: assert reset=0 for 3 cycles. Required: busy=0, uart_we=0, uart_re=0, no ack. After release, a pending req is re-granted starting from requester 0.
- Back-to-back from one requester: req[1] held high across ack. Required: a second transfer starts in LOAD exactly 2 cycles after DONE (DONE→IDLE→LOAD).

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the controller state enum, UART register map and status bits.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GO,
        POLL,
        ABORT,
        DONE
    } state_t;

    localparam logic [1:0] REG_DOUT   = 2'b00;
    localparam logic [1:0] REG_DIN    = 2'b01;
    localparam logic [1:0] REG_STATUS = 2'b10;

    localparam logic [7:0] STATUS_GO       = 8'h01;
    localparam int         STATUS_BUSY_BIT = 1;
    localparam int         STATUS_GO_BIT   = 0;

    // Next round-robin index after v, wrapping at n.
    function automatic logic [2:0] wrap_inc(
        input logic [2:0] v,
        input int         n
    );
        return (int'(v) == n - 1) ? 3'd0 : v + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req, ptr in; one-hot grant and binary grant_idx out.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [N-1:0] grant,
    output logic [2:0]   grant_idx
);

    logic found;

    // Step k visits requester (ptr + k) mod N; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] &&
                    ((int'(ptr) + k == i) ||
                     (int'(ptr) + k == i + N))) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = 3'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one register-mapped UART transmitter among NUM_REQ producers.
// Ports: req/req_data in, ack/err/busy/grant_id out, UART register bus.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 err,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 uart_we,
    output logic                 uart_re,
    output logic [1:0]           uart_sel,
    output logic [7:0]           uart_wdata,
    input  logic [7:0]           uart_rdata
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t               state;
    state_t               state_nx;
    logic [2:0]           rr_ptr;
    logic [7:0]           byte_q;
    logic [15:0]          tmo_cnt;
    logic                 timed_out;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [2:0]           arb_idx;
    logic [7:0]           arb_byte;
    logic                 any_req;
    logic                 poll_clear;
    logic                 tmo_hit;
    logic                 unused_rdata;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign any_req      = |arb_grant;
    assign poll_clear   = ~uart_rdata[STATUS_GO_BIT];
    assign tmo_hit      = (tmo_cnt == TMO_LAST);
    assign unused_rdata = ^uart_rdata;

    // Byte mux driven by the one-hot grant.
    always_comb begin
        arb_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                arb_byte = arb_byte | req_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = LOAD;
            LOAD:    state_nx = GO;
            GO:      state_nx = POLL;
            POLL: begin
                if (poll_clear) begin
                    state_nx = DONE;
                end else if (tmo_hit) begin
                    state_nx = ABORT;
                end
            end
            ABORT:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        uart_we    = 1'b0;
        uart_re    = 1'b0;
        uart_sel   = REG_DOUT;
        uart_wdata = 8'h00;
        unique case (state)
            LOAD: begin
                uart_we    = 1'b1;
                uart_sel   = REG_DOUT;
                uart_wdata = byte_q;
            end
            GO: begin
                uart_we    = 1'b1;
                uart_sel   = REG_STATUS;
                uart_wdata = STATUS_GO;
            end
            POLL: begin
                uart_re  = 1'b1;
                uart_sel = REG_STATUS;
            end
            // Cancel the stuck transmission before reporting it.
            ABORT: begin
                uart_we    = 1'b1;
                uart_sel   = REG_STATUS;
                uart_wdata = 8'h00;
            end
            default: ;
        endcase
    end

    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (state == DONE) && (grant_id == 3'(i));
        end
    end

    assign err  = (state == DONE) && timed_out;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            byte_q    <= '0;
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= arb_idx;
                        byte_q   <= arb_byte;
                    end
                end
                GO: tmo_cnt <= '0;
                POLL: begin
                    if (poll_clear) begin
                        timed_out <= 1'b0;
                    end else if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ABORT: timed_out <= 1'b1;
                DONE: begin
                    rr_ptr    <= wrap_inc(grant_id, NUM_REQ);
                    timed_out <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART register model.
// A second instance with an 8-cycle timeout covers the abort path.
module tb_uart_tx_arbiter;
    import uart_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        err, busy;
    logic [2:0]  grant_id;
    logic        uart_we, uart_re;
    logic [1:0]  uart_sel;
    logic [7:0]  uart_wdata, uart_rdata;

    logic [1:0]  req_t;
    logic [15:0] req_data_t;
    logic [1:0]  ack_t;
    logic        err_t, busy_t;
    logic [2:0]  grant_id_t;
    logic        we_t, re_t;
    logic [1:0]  sel_t;
    logic [7:0]  wdata_t, rdata_t;

    int n_cmp = 0;
    int n_bad = 0;
    int viol = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ (4), .TIMEOUT_CYCLES (65535)
    ) dut (
        .clk (clk), .reset (reset), .req (req), .req_data (req_data),
        .ack (ack), .err (err), .busy (busy), .grant_id (grant_id),
        .uart_we (uart_we), .uart_re (uart_re), .uart_sel (uart_sel),
        .uart_wdata (uart_wdata), .uart_rdata (uart_rdata)
    );

    uart_tx_arbiter #(
        .NUM_REQ (2), .TIMEOUT_CYCLES (8)
    ) dut_t (
        .clk (clk), .reset (reset), .req (req_t), .req_data (req_data_t),
        .ack (ack_t), .err (err_t), .busy (busy_t), .grant_id (grant_id_t),
        .uart_we (we_t), .uart_re (re_t), .uart_sel (sel_t),
        .uart_wdata (wdata_t), .uart_rdata (rdata_t)
    );

    // UART model: GO stays set for delay_m cycles after the GO write.
    logic       go_m;
    int         cnt_m;
    int         delay_m = 1;
    logic [7:0] dout_m;
    logic [7:0] tx_q[$];
    logic [9:0] wr_q[$];
    int         reads_m = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            go_m   <= 1'b0;
            cnt_m  <= 0;
            dout_m <= 8'h00;
        end else begin
            if (uart_we) wr_q.push_back({uart_sel, uart_wdata});
            if (uart_re) reads_m <= reads_m + 1;
            if (uart_we && uart_sel == REG_DOUT) dout_m <= uart_wdata;
            if (uart_we && uart_sel == REG_STATUS) begin
                if (uart_wdata[0]) begin
                    go_m  <= 1'b1;
                    cnt_m <= delay_m;
                    tx_q.push_back(dout_m);
                end else begin
                    go_m <= 1'b0;
                end
            end else if (go_m) begin
                if (cnt_m <= 1) go_m <= 1'b0;
                else cnt_m <= cnt_m - 1;
            end
        end
    end

    assign uart_rdata = uart_re ? {6'b0, go_m, go_m} : 8'h00;

    // Stuck UART for the timeout instance: GO only clears by a write.
    logic go_t;
    always @(posedge clk or negedge reset) begin
        if (!reset) go_t <= 1'b0;
        else if (we_t && sel_t == REG_STATUS) go_t <= wdata_t[0];
    end
    assign rdata_t = re_t ? {7'b0, go_t} : 8'h00;

    always @(negedge clk) begin
        if ((uart_we && uart_re) || (we_t && re_t) ||
            (uart_sel == REG_DIN) || (sel_t == REG_DIN) ||
            !$onehot0(ack) || !$onehot0(ack_t))
            viol <= viol + 1;
    end

    function automatic int idx_of(input logic [3:0] v);
        idx_of = -1;
        for (int i = 0; i < 4; i++) if (v[i]) idx_of = i;
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, err, ack, grant_id, uart_we, uart_re} !== 11'd0) begin
                n_bad++;
                $display("FAIL reset_outs c%0d: got %b want 0", c,
                         {busy, err, ack, grant_id, uart_we, uart_re});
            end
        end
        n_cmp++;
        if ({uart_sel, uart_wdata, busy_t, ack_t} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h want 0",
                     {uart_sel, uart_wdata, busy_t, ack_t});
        end
        reset = 1'b1;
    endtask

    task automatic test_contention();
        int got = 0;
        int order[5];
        int want[5] = '{0, 1, 2, 3, 0};
        int tb = tx_q.size();
        logic [7:0] wb;
        @(negedge clk);
        delay_m  = 3;
        req_data = 32'hA3A2A1A0;
        req      = 4'hF;
        for (int c = 0; c < 400 && got < 5; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                order[got] = idx_of(ack);
                got++;
                if (got == 5) req = 4'h0;
            end
        end
        n_cmp++;
        if (got !== 5) begin
            n_bad++;
            $display("FAIL contention_acks: got %0d want 5", got);
        end
        for (int i = 0; i < got; i++) begin
            n_cmp++;
            if (order[i] !== want[i]) begin
                n_bad++;
                $display("FAIL contention_order[%0d]: got %0d want %0d",
                         i, order[i], want[i]);
            end
            wb = 8'hA0 + 8'(want[i]);
            n_cmp++;
            if (tx_q.size() <= tb + i || tx_q[tb+i] !== wb) begin
                n_bad++;
                $display("FAIL contention_tx[%0d]: got %h want %h", i,
                         (tx_q.size() > tb + i) ? tx_q[tb+i] : 8'hxx, wb);
            end
        end
    endtask

    task automatic test_single();
        int ack_cyc = -1;
        int wb = wr_q.size();
        int rb = reads_m;
        int tb = tx_q.size();
        @(negedge clk);
        delay_m  = 20;
        req_data = 32'h00000041;
        req      = 4'b0001;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                ack_cyc = c;
                break;
            end
        end
        n_cmp++;
        if (ack_cyc !== 24) begin
            n_bad++;
            $display("FAIL single_latency: got %0d want 24", ack_cyc);
        end
        n_cmp++;
        if ({ack, err, grant_id} !== {4'b0001, 1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL single_ack: got %b want 0001_0_000",
                     {ack, err, grant_id});
        end
        req = 4'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, ack} !== 5'b0) begin
            n_bad++;
            $display("FAIL single_idle: got %b want 0", {busy, ack});
        end
        n_cmp++;
        if (wr_q.size() - wb !== 2 ||
            wr_q[wb] !== {REG_DOUT, 8'h41} ||
            wr_q[wb+1] !== {REG_STATUS, 8'h01}) begin
            n_bad++;
            $display("FAIL single_writes: got n=%0d want DOUT41,STATUS01",
                     wr_q.size() - wb);
        end
        n_cmp++;
        if (reads_m - rb !== 21) begin
            n_bad++;
            $display("FAIL single_polls: got %0d want 21", reads_m - rb);
        end
        n_cmp++;
        if (tx_q.size() != tb + 1 || tx_q[tb] !== 8'h41) begin
            n_bad++;
            $display("FAIL single_tx: got n=%0d want one 41",
                     tx_q.size() - tb);
        end
    endtask

    task automatic test_min_latency();
        int ack_cyc = -1;
        @(negedge clk);
        delay_m  = 1;
        req_data = 32'h005A0000;
        req      = 4'b0100;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                ack_cyc = c;
                break;
            end
        end
        n_cmp++;
        if (ack_cyc !== 5 || ack !== 4'b0100) begin
            n_bad++;
            $display("FAIL min_latency: got cyc %0d ack %b want 5 0100",
                     ack_cyc, ack);
        end
        req = 4'b0;
    endtask

    task automatic test_rr_pointer();
        int got = 0;
        int order[2];
        @(negedge clk);
        delay_m  = 2;
        req_data = 32'h00C200C0;
        req      = 4'b0101;
        for (int c = 0; c < 200 && got < 2; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                order[got] = idx_of(ack);
                got++;
                req = req & ~ack;
            end
        end
        n_cmp++;
        if (got !== 2 || order[0] !== 0 || order[1] !== 2) begin
            n_bad++;
            $display("FAIL rr_order: got n=%0d %0d,%0d want 0,2",
                     got, order[0], order[1]);
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        @(negedge clk);
        delay_m  = 2;
        req_data = 32'h00007700;
        req      = 4'b0010;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) break;
        end
        n_cmp++;
        if (ack !== 4'b0010) begin
            n_bad++;
            $display("FAIL b2b_ack1: got %b want 0010", ack);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got %b want 0", busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({uart_we, uart_sel, uart_wdata} !== {1'b1, REG_DOUT, 8'h77}) begin
            n_bad++;
            $display("FAIL b2b_load: got %h want %h",
                     {uart_we, uart_sel, uart_wdata},
                     {1'b1, REG_DOUT, 8'h77});
        end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                got = idx_of(ack);
                break;
            end
        end
        req = 4'b0;
        n_cmp++;
        if (got !== 1) begin
            n_bad++;
            $display("FAIL b2b_ack2: got %0d want 1", got);
        end
    endtask

    task automatic test_timeout();
        int ack_cyc = -1;
        int polls = 0;
        logic [10:0] prev = '0;
        @(negedge clk);
        req_data_t = 16'h00C3;
        req_t      = 2'b01;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (re_t) polls++;
            if (ack_t !== 2'b0) begin
                ack_cyc = c;
                break;
            end
            prev = {we_t, sel_t, wdata_t};
        end
        n_cmp++;
        if (polls !== 8 || ack_cyc !== 12) begin
            n_bad++;
            $display("FAIL tmo_polls: got %0d@%0d want 8@12", polls, ack_cyc);
        end
        n_cmp++;
        if ({ack_t, err_t} !== 3'b011) begin
            n_bad++;
            $display("FAIL tmo_ack_err: got %b want 011", {ack_t, err_t});
        end
        n_cmp++;
        if (prev !== {1'b1, REG_STATUS, 8'h00}) begin
            n_bad++;
            $display("FAIL tmo_abort_wr: got %h want %h", prev,
                     {1'b1, REG_STATUS, 8'h00});
        end
        req_t = 2'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy_t, err_t, ack_t} !== 4'b0) begin
            n_bad++;
            $display("FAIL tmo_idle: got %b want 0", {busy_t, err_t, ack_t});
        end
    endtask

    task automatic test_async_reset();
        int got = 0;
        int order[2] = '{-1, -1};
        @(negedge clk);
        delay_m  = 100;
        req_data = 32'hB300B100;
        req      = 4'b1010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (uart_re) break;
        end
        n_cmp++;
        if ({uart_re, grant_id} !== {1'b1, 3'd3}) begin
            n_bad++;
            $display("FAIL ar_pre: got %b want 1_011", {uart_re, grant_id});
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, uart_we, uart_re, ack} !== 7'b0) begin
            n_bad++;
            $display("FAIL ar_immediate: got %b want 0",
                     {busy, uart_we, uart_re, ack});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, uart_we, uart_re, ack} !== 7'b0) begin
                n_bad++;
                $display("FAIL ar_hold c%0d: got %b want 0", c,
                         {busy, uart_we, uart_re, ack});
            end
        end
        delay_m = 2;
        reset   = 1'b1;
        for (int c = 0; c < 200 && got < 2; c++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                order[got] = idx_of(ack);
                got++;
                req = req & ~ack;
            end
        end
        n_cmp++;
        if (got !== 2 || order[0] !== 1 || order[1] !== 3) begin
            n_bad++;
            $display("FAIL ar_regrant: got n=%0d %0d,%0d want 1,3",
                     got, order[0], order[1]);
        end
    endtask

    task automatic test_bus_rules();
        @(negedge clk);
        n_cmp++;
        if (viol !== 0) begin
            n_bad++;
            $display("FAIL bus_rules: got %0d violations want 0", viol);
        end
    endtask

    initial begin
        reset      = 1'b0;
        req        = 4'b0;
        req_data   = 32'h0;
        req_t      = 2'b0;
        req_data_t = 16'h0;
        test_reset();
        test_contention();
        test_single();
        test_min_latency();
        test_rr_pointer();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        test_bus_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
